bit_serializer: RTL and testbench

Parallel-to-serial front end that feeds the "1011" sequence detector's single-bit `in` input. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, with no gaps between back-to-back words. When no word is in flight it drives a defined idle level, so the detector always sees a clean stream.

---
 rtl/bit_serializer.sv | 123 ++++++++++++
 tb/tb_bit_serializer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the "1011" detector: WIDTH-bit words in over valid/ready, one bit per clock out.
// Optional build macro SER_PARITY_EN appends one even-parity bit to every frame.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             last_bit,
  output logic [5:0]       bit_cnt,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
  localparam logic [5:0] DATA_LAST = 6'(WIDTH - 1);
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [5:0] LAST_IDX = 6'(FRAME - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             ser_out_n, ser_valid_n, last_bit_n;
  logic [5:0]       bit_cnt_n;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             par, par_n;
`endif

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign busy      = (state == SHIFT);
  assign din_ready = (state == IDLE) || last_bit;
  assign accept    = din_valid && din_ready;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_n     = state;
    shreg_n     = shreg;
    ser_out_n   = ser_out;
    ser_valid_n = ser_valid;
    last_bit_n  = last_bit;
    bit_cnt_n   = bit_cnt;
`ifdef SER_PARITY_EN
    par_n       = par;
`endif
    if (accept) begin
      // New frame: covers both the IDLE start and the back-to-back reload on the last bit.
      state_n     = SHIFT;
      ser_out_n   = head(din);
      shreg_n     = advance(din);
      ser_valid_n = 1'b1;
      last_bit_n  = 1'b0;
      bit_cnt_n   = 6'd0;
`ifdef SER_PARITY_EN
      par_n       = ^din;
`endif
    end else if (state == SHIFT) begin
      if (last_bit) begin
        state_n     = IDLE;
        ser_out_n   = IDLE_BIT;
        ser_valid_n = 1'b0;
        last_bit_n  = 1'b0;
        bit_cnt_n   = 6'd0;
      end else begin
        bit_cnt_n  = bit_cnt + 6'd1;
        last_bit_n = (bit_cnt + 6'd1 == LAST_IDX);
`ifdef SER_PARITY_EN
        if (bit_cnt == DATA_LAST) begin
          ser_out_n = par;
        end else begin
          ser_out_n = head(shreg);
          shreg_n   = advance(shreg);
        end
`else
        ser_out_n = head(shreg);
        shreg_n   = advance(shreg);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      last_bit  <= 1'b0;
      bit_cnt   <= 6'd0;
`ifdef SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      ser_out   <= ser_out_n;
      ser_valid <= ser_valid_n;
      last_bit  <= last_bit_n;
      bit_cnt   <= bit_cnt_n;
`ifdef SER_PARITY_EN
      par       <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: table-driven cycle vectors plus hand sequences
// for mid-word reset, reset/valid collision, LSB-first order and (if SER_PARITY_EN) parity.
module tb_bit_serializer;

`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, ser_out, ser_valid, last_bit, busy;
  logic [5:0] bit_cnt;

  logic [7:0] din_l = 8'h00;
  logic       din_valid_l = 1'b0;
  logic       din_ready_l, ser_out_l, ser_valid_l, last_bit_l, busy_l;
  logic [5:0] bit_cnt_l;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .last_bit(last_bit), .bit_cnt(bit_cnt), .busy(busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
    .ser_out(ser_out_l), .ser_valid(ser_valid_l), .last_bit(last_bit_l), .bit_cnt(bit_cnt_l), .busy(busy_l)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] din;
    logic       so;
    logic       sv;
    logic       lb;
    logic [5:0] cnt;
    logic       busy;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic r, input logic v, input logic [7:0] d, input logic so,
                      input logic sv, input logic lb, input logic [5:0] cnt, input logic b,
                      input logic rdy);
    vec_t t;
    t.rst = r; t.valid = v; t.din = d; t.so = so; t.sv = sv; t.lb = lb;
    t.cnt = cnt; t.busy = b; t.rdy = rdy;
    vecs.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] snap();
    return {ser_out, ser_valid, last_bit, busy, din_ready, bit_cnt};
  endfunction

  initial begin
    logic [7:0] lsb_exp;

    // Reset and idle.
    push(1, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    push(1, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    push(0, 0, 8'hB0, 0, 0, 0, 0, 0, 1);
    // Single word 8'hB0, MSB first: 1,0,1,1,0,0,0,0.
    push(0, 1, 8'hB0, 1, 1, 0, 0, 1, 0);
    push(0, 0, 8'hB0, 0, 1, 0, 1, 1, 0);
    push(0, 0, 8'hB0, 1, 1, 0, 2, 1, 0);
    push(0, 0, 8'hB0, 1, 1, 0, 3, 1, 0);
    push(0, 0, 8'hB0, 0, 1, 0, 4, 1, 0);
    push(0, 0, 8'hB0, 0, 1, 0, 5, 1, 0);
    push(0, 0, 8'hB0, 0, 1, 0, 6, 1, 0);
    push(0, 0, 8'hB0, 0, 1, !PAR, 7, 1, !PAR);
    if (PAR) push(0, 0, 8'hB0, 1, 1, 1, 8, 1, 1);
    push(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    // Back-to-back 8'hB0 then 8'h0B; din changes to 0B while busy must not disturb the first word.
    push(0, 1, 8'hB0, 1, 1, 0, 0, 1, 0);
    push(0, 1, 8'h0B, 0, 1, 0, 1, 1, 0);
    push(0, 1, 8'h0B, 1, 1, 0, 2, 1, 0);
    push(0, 1, 8'h0B, 1, 1, 0, 3, 1, 0);
    push(0, 1, 8'h0B, 0, 1, 0, 4, 1, 0);
    push(0, 1, 8'h0B, 0, 1, 0, 5, 1, 0);
    push(0, 1, 8'h0B, 0, 1, 0, 6, 1, 0);
    push(0, 1, 8'h0B, 0, 1, !PAR, 7, 1, !PAR);
    if (PAR) push(0, 1, 8'h0B, 1, 1, 1, 8, 1, 1);
    // Second word 8'h0B: 0,0,0,0,1,0,1,1 with zero idle gap.
    push(0, 1, 8'h0B, 0, 1, 0, 0, 1, 0);
    push(0, 0, 8'h0B, 0, 1, 0, 1, 1, 0);
    push(0, 0, 8'h0B, 0, 1, 0, 2, 1, 0);
    push(0, 0, 8'h0B, 0, 1, 0, 3, 1, 0);
    push(0, 0, 8'h0B, 1, 1, 0, 4, 1, 0);
    push(0, 0, 8'h0B, 0, 1, 0, 5, 1, 0);
    push(0, 0, 8'h0B, 1, 1, 0, 6, 1, 0);
    push(0, 0, 8'h0B, 1, 1, !PAR, 7, 1, !PAR);
    if (PAR) push(0, 0, 8'h0B, 1, 1, 1, 8, 1, 1);
    push(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; din_valid = vecs[i].valid; din = vecs[i].din;
      step();
      check($sformatf("vec%0d {so,sv,lb,busy,rdy,cnt}", i), 32'(snap()),
            32'({vecs[i].so, vecs[i].sv, vecs[i].lb, vecs[i].busy, vecs[i].rdy, vecs[i].cnt}));
    end

    // Reset mid-word at bit_cnt=3 of 8'hFF: discarded, no last_bit pulse.
    din = 8'hFF; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step(); step(); step();
    check("mid_word_at_cnt3", 32'(snap()), 32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd3}));
    rst = 1'b1;
    step();
    check("mid_word_reset", 32'(snap()), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0}));
    // rst and din_valid on the same edge: rst wins.
    din = 8'h80; din_valid = 1'b1;
    step();
    check("rst_beats_valid", 32'(snap()), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0}));
    rst = 1'b0;
    step();
    check("after_reset_bit0", 32'(snap()), 32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0}));
    din_valid = 1'b0;
    step();
    check("after_reset_bit1", 32'(snap()), 32'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd1}));
    for (int i = 2; i < 8 + int'(PAR); i++) step();
    check("after_reset_last", 32'({last_bit, din_ready, bit_cnt}), 32'({1'b1, 1'b1, 6'(7 + int'(PAR))}));
    step();
    check("after_reset_idle", 32'(snap()), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0}));

    // LSB-first instance: 8'h0D -> 1,0,1,1,0,0,0,0.
    lsb_exp = 8'b0000_1101;
    din_l = 8'h0D; din_valid_l = 1'b1;
    step();
    din_valid_l = 1'b0; din_l = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lsb_bit%0d {so,sv,cnt}", i), 32'({ser_out_l, ser_valid_l, bit_cnt_l}),
            32'({lsb_exp[i], 1'b1, 6'(i)}));
      check($sformatf("lsb_last%0d", i), 32'(last_bit_l), 32'((i == 7) && !PAR));
      step();
    end

`ifdef SER_PARITY_EN
    // 8'h03 has two ones: parity bit 0 at bit_cnt=8.
    step(); step();
    din = 8'h03; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("parity_03", 32'({ser_out, ser_valid, last_bit, bit_cnt}), 32'({1'b0, 1'b1, 1'b1, 6'd8}));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
